// File: rtl/fp_norm_seq_pkg.sv
// Shared widths and FSM state type for the FP normalization sequencer.
package fp_norm_pkg;

    localparam int MANT_W  = 24;
    localparam int EXP_W   = 8;
    localparam int SEL_W   = 5;
    localparam int NIB_CNT = 6;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        HOLD
    } state_t;

endpackage

// File: rtl/fp_norm_seq_if.sv
// Operand/result handshake bundle for fp_norm_seq; slave is the sequencer side.
interface fp_norm_seq_if;
    import fp_norm_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [MANT_W-1:0] out_mant;
    logic              out_zero;
    logic              out_uflow;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_uflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_uflow
    );

endinterface

// File: rtl/fp_norm_seq_lz.sv
// 4-bit leading-zero encoder; an all-zero nibble reports zero=1 with lz=0.
module fp_nib_lz (
    input  logic [3:0] nib,
    output logic [1:0] lz,
    output logic       zero
);

    always_comb begin
        lz   = 2'd0;
        zero = 1'b0;
        casez (nib)
            4'b1???: lz = 2'd0;
            4'b01??: lz = 2'd1;
            4'b001?: lz = 2'd2;
            4'b0001: lz = 2'd3;
            default: zero = 1'b1;
        endcase
    end

endmodule

// File: rtl/fp_norm_seq.sv
// Nibble-serial leading-zero scan driving an external left shifter for one cycle.
// Optional gradual underflow is enabled by defining FP_NORM_DENORM_EN.
module fp_norm_seq
    import fp_norm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    fp_norm_seq_if.slave      bus,
    output logic [SEL_W-1:0]  sh_sel,
    output logic [MANT_W-1:0] sh_f,
    input  logic [MANT_W-1:0] sh_q,
    output logic              busy
);

    state_t            state, state_nxt;
    logic              sign_r;
    logic [EXP_W-1:0]  exp_r;
    logic [MANT_W-1:0] mant_r;
    logic [SEL_W-1:0]  lz_cnt;
    logic [2:0]        nib_idx;
    logic              out_sign_r;
    logic [EXP_W-1:0]  out_exp_r;
    logic [MANT_W-1:0] out_mant_r;
    logic              out_zero_r;
    logic              out_uflow_r;

    logic [3:0]        nib;
    logic [1:0]        nib_lz;
    logic              nib_zero;
    logic [EXP_W-1:0]  lz_ext;
    logic              uflow;
    logic              last_nib;

    // Nibble 0 is the most significant one (bits 23:20).
    always_comb begin
        nib = mant_r[3:0];
        case (nib_idx)
            3'd0:    nib = mant_r[23:20];
            3'd1:    nib = mant_r[19:16];
            3'd2:    nib = mant_r[15:12];
            3'd3:    nib = mant_r[11:8];
            3'd4:    nib = mant_r[7:4];
            default: nib = mant_r[3:0];
        endcase
    end

    fp_nib_lz u_nib_lz (
        .nib  (nib),
        .lz   (nib_lz),
        .zero (nib_zero)
    );

    assign lz_ext   = {{(EXP_W-SEL_W){1'b0}}, lz_cnt};
    assign uflow    = (lz_ext >= exp_r);
    assign last_nib = (nib_idx == 3'(NIB_CNT-1));

`ifdef FP_NORM_DENORM_EN
    logic [EXP_W-1:0] exp_m1;
    logic [SEL_W-1:0] dn_amt;
    // On underflow lz_cnt >= exp_r, so exp_r-1 always fits the shift width.
    assign exp_m1 = exp_r - EXP_W'(1);
    assign dn_amt = (exp_r == '0) ? '0 : exp_m1[SEL_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sh_sel    = '0;
        case (state)
            IDLE: begin
                if (bus.in_valid) state_nxt = SCAN;
            end
            SCAN: begin
                if (!nib_zero)     state_nxt = SHIFT;
                else if (last_nib) state_nxt = HOLD;
            end
            SHIFT: begin
`ifdef FP_NORM_DENORM_EN
                sh_sel = uflow ? dn_amt : lz_cnt;
`else
                sh_sel = lz_cnt;
`endif
                state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_r      <= 1'b0;
            exp_r       <= '0;
            mant_r      <= '0;
            lz_cnt      <= '0;
            nib_idx     <= '0;
            out_sign_r  <= 1'b0;
            out_exp_r   <= '0;
            out_mant_r  <= '0;
            out_zero_r  <= 1'b0;
            out_uflow_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_r  <= bus.in_sign;
                        exp_r   <= bus.in_exp;
                        mant_r  <= bus.in_mant;
                        lz_cnt  <= '0;
                        nib_idx <= '0;
                    end
                end
                SCAN: begin
                    if (!nib_zero) begin
                        lz_cnt <= lz_cnt + {{(SEL_W-2){1'b0}}, nib_lz};
                    end else begin
                        lz_cnt  <= lz_cnt + SEL_W'(4);
                        nib_idx <= nib_idx + 3'd1;
                        if (last_nib) begin
                            out_sign_r  <= sign_r;
                            out_zero_r  <= 1'b1;
                            out_mant_r  <= '0;
                            out_exp_r   <= '0;
                            out_uflow_r <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    out_sign_r <= sign_r;
                    out_zero_r <= 1'b0;
                    if (uflow) begin
`ifdef FP_NORM_DENORM_EN
                        out_mant_r <= sh_q;
`else
                        out_mant_r <= '0;
`endif
                        out_exp_r   <= '0;
                        out_uflow_r <= 1'b1;
                    end else begin
                        out_mant_r  <= sh_q;
                        out_exp_r   <= exp_r - lz_ext;
                        out_uflow_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sign  = out_sign_r;
    assign bus.out_exp   = out_exp_r;
    assign bus.out_mant  = out_mant_r;
    assign bus.out_zero  = out_zero_r;
    assign bus.out_uflow = out_uflow_r;
    assign busy          = (state != IDLE);
    assign sh_f          = mant_r;

endmodule
